// File: rtl/mult_div_pkg.sv
// Shared types and constants for the mult/div arbiter slice.
// State and owner encodings plus the abort result value.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        ACK  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam int          TIMEOUT_DEF  = 64;
    localparam logic [31:0] RESULT_ABORT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_arbiter_if.sv
// Bus between the arbiter and the shared sequential mult/div unit.
// master drives operands and go; slave returns result and done.
interface mult_div_arbiter_if;

    logic [31:0] ent_32;
    logic [15:0] ent_16;
    logic        div_mult;
    logic        go;
    logic [31:0] sal_32;
    logic        done;

    modport master (
        output ent_32, ent_16, div_mult, go,
        input  sal_32, done
    );

    modport slave (
        input  ent_32, ent_16, div_mult, go,
        output sal_32, done
    );

endinterface

// File: rtl/mult_div_arbiter_rr_arb2.sv
// Two-way round-robin pick; combinational.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
    import mult_div_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last_grant,
    output logic   valid,
    output owner_t pick
);

    // Pick the lone requester, or alternate on a tie
    always_comb begin
        valid = req_a | req_b;
        pick  = OWN_A;
        if (req_a && req_b)
            pick = (last_grant == OWN_A) ? OWN_B : OWN_A;
        else if (req_b)
            pick = OWN_B;
    end

endmodule

// File: rtl/mult_div_arbiter.sv
// Shares one sequential mult/div unit between requesters A and B.
// Round-robin grant, go/done sequencing, four-phase reply, watchdog.
module mult_div_arbiter
    import mult_div_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_a,
    input  logic                div_mult_a,
    input  logic [31:0]         ent_32_a,
    input  logic [15:0]         ent_16_a,
    output logic                ack_a,
    output logic [31:0]         sal_32_a,
    input  logic                req_b,
    input  logic                div_mult_b,
    input  logic [31:0]         ent_32_b,
    input  logic [15:0]         ent_16_b,
    output logic                ack_b,
    output logic [31:0]         sal_32_b,
    output logic                err,
    mult_div_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    owner_t           owner;
    owner_t           last_grant;
    owner_t           pick;
    logic             pick_v;
    logic [CNT_W-1:0] cnt;
    logic             own_req;
    logic             finish;
    logic [31:0]      res;

    rr_arb2 u_rr_arb2 (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant),
        .valid      (pick_v),
        .pick       (pick)
    );

    // Owner's request line and the value to hand back when RUN ends
    always_comb begin
        own_req = (owner == OWN_A) ? req_a : req_b;
        finish  = bus.done || (cnt == CNT_LAST);
        res     = bus.done ? bus.sal_32 : RESULT_ABORT;
    end

    // Arbiter FSM with registered unit-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= OWN_A;
            last_grant   <= OWN_B;
            cnt          <= '0;
            err          <= 1'b0;
            ack_a        <= 1'b0;
            ack_b        <= 1'b0;
            sal_32_a     <= '0;
            sal_32_b     <= '0;
            bus.go       <= 1'b0;
            bus.ent_32   <= '0;
            bus.ent_16   <= '0;
            bus.div_mult <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_v) begin
                        owner      <= pick;
                        last_grant <= pick;
                        state      <= ARM;
                        if (pick == OWN_A) begin
                            bus.ent_32   <= ent_32_a;
                            bus.ent_16   <= ent_16_a;
                            bus.div_mult <= div_mult_a;
                        end else begin
                            bus.ent_32   <= ent_32_b;
                            bus.ent_16   <= ent_16_b;
                            bus.div_mult <= div_mult_b;
                        end
                    end
                end
                ARM: begin
                    bus.go <= 1'b0;
                    if (!bus.done) begin
                        bus.go <= 1'b1;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (finish) begin
                        bus.go <= 1'b0;
                        state  <= ACK;
                        if (!bus.done)
                            err <= 1'b1;
                        if (owner == OWN_A) begin
                            sal_32_a <= res;
                            ack_a    <= 1'b1;
                        end else begin
                            sal_32_b <= res;
                            ack_b    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (!own_req) begin
                        ack_a <= 1'b0;
                        ack_b <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_arbiter.sv
// Self-checking bench for mult_div_arbiter with a behavioural unit model.
// Vector table plus hand sequences; scoreboard queue of expected replies.
module tb_mult_div_arbiter;
    import mult_div_pkg::*;

    localparam int K = 5;

    typedef struct {
        bit          who;
        bit          dm;
        logic [31:0] e32;
        logic [15:0] e16;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          who;
        logic [31:0] val;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, div_mult_a, ack_a;
    logic [31:0] ent_32_a, sal_32_a;
    logic [15:0] ent_16_a;
    logic        req_b, div_mult_b, ack_b;
    logic [31:0] ent_32_b, sal_32_b;
    logic [15:0] ent_16_b;
    logic        err;

    int  total = 0;
    int  bad   = 0;
    sb_t sb[$];
    logic [31:0] shadow_a, shadow_b;

    bit          hold  = 1'b0;
    bit          stall = 1'b0;
    logic [3:0]  mcnt  = '0;
    logic        done_m = 1'b0;
    logic [31:0] msal  = '0;

    mult_div_arbiter_if bus ();

    mult_div_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .div_mult_a (div_mult_a),
        .ent_32_a   (ent_32_a),
        .ent_16_a   (ent_16_a),
        .ack_a      (ack_a),
        .sal_32_a   (sal_32_a),
        .req_b      (req_b),
        .div_mult_b (div_mult_b),
        .ent_32_b   (ent_32_b),
        .ent_16_b   (ent_16_b),
        .ack_b      (ack_b),
        .sal_32_b   (sal_32_b),
        .err        (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Unit model: done rises K cycles after go, clears a cycle after go drops
    always @(posedge clk) begin
        if (bus.go !== 1'b1) begin
            mcnt   <= '0;
            done_m <= 1'b0;
        end else if (!done_m) begin
            mcnt <= mcnt + 1'b1;
            if (mcnt == 4'(K - 1)) begin
                done_m <= 1'b1;
                if (bus.div_mult)
                    msal <= {16'h0, bus.ent_32[15:0]} * {16'h0, bus.ent_16};
                else if (bus.ent_16 == 16'h0)
                    msal <= 32'hFFFF_FFFF;
                else
                    msal <= bus.ent_32 / {16'h0, bus.ent_16};
            end
        end
    end

    assign bus.done   = hold | (done_m & ~stall);
    assign bus.sal_32 = msal;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic set_req(input bit who, input bit dm, input logic [31:0] e32,
                           input logic [15:0] e16, input logic [31:0] exp);
        if (who) begin
            div_mult_b = dm; ent_32_b = e32; ent_16_b = e16; req_b = 1'b1;
        end else begin
            div_mult_a = dm; ent_32_a = e32; ent_16_a = e16; req_a = 1'b1;
        end
        sb.push_back('{who: who, val: exp});
    endtask

    task automatic wait_ack(input int bound, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < bound && !ok) begin
            @(negedge clk);
            cyc++;
            if (ack_a || ack_b) ok = 1'b1;
        end
        if (!ok) fail_to("ack_wait");
    endtask

    task automatic pop_check();
        sb_t e;
        bit  who;
        who = ack_b;
        if (sb.size() == 0) begin
            fail_to("sb_empty");
            return;
        end
        e = sb.pop_front();
        chk("sb_owner", 32'(who), 32'(e.who));
        if (who) begin
            chk("sal_b", sal_32_b, e.val);
            chk("sal_a_kept", sal_32_a, shadow_a);
            chk("ack_a_low", 32'(ack_a), 32'd0);
            shadow_b = e.val;
        end else begin
            chk("sal_a", sal_32_a, e.val);
            chk("sal_b_kept", sal_32_b, shadow_b);
            chk("ack_b_low", 32'(ack_b), 32'd0);
            shadow_a = e.val;
        end
    endtask

    task automatic drop(input bit who);
        if (who) req_b = 1'b0; else req_a = 1'b0;
        @(negedge clk);
        chk(who ? "ack_b_drop" : "ack_a_drop", 32'(who ? ack_b : ack_a), 32'd0);
    endtask

    task automatic do_vec(input vec_t v, input bit timing);
        int cyc, gcyc;
        bit ok;
        set_req(v.who, v.dm, v.e32, v.e16, v.exp);
        cyc = 0; gcyc = 0; ok = 1'b0;
        while (cyc < 200 && !ok) begin
            @(negedge clk);
            cyc++;
            if (bus.go && gcyc == 0) begin
                gcyc = cyc;
                if (v.who) ent_32_b = $urandom; else ent_32_a = $urandom;
            end
            if (ack_a || ack_b) ok = 1'b1;
        end
        if (!ok) fail_to("vec_ack");
        if (timing) begin
            chk("go_latency", 32'(gcyc), 32'd2);
            chk("ack_latency", 32'(cyc), 32'(3 + K));
        end
        chk("unit_div_mult", 32'(bus.div_mult), 32'(v.dm));
        chk("unit_ent_16", 32'(bus.ent_16), 32'(v.e16));
        chk("go_low_ack", 32'(bus.go), 32'd0);
        pop_check();
        drop(v.who);
        repeat (2) @(negedge clk);
    endtask

    task automatic tie_pair();
        int cyc;
        bit ok;
        set_req(1'b0, 1'b1, 32'd7, 16'd6, 32'd42);
        set_req(1'b1, 1'b0, 32'd81, 16'd9, 32'd9);
        wait_ack(200, cyc, ok);
        chk("tie_first_a", 32'(ack_a), 32'd1);
        chk("tie_ent_32_a", bus.ent_32, 32'd7);
        pop_check();
        drop(1'b0);
        set_req(1'b0, 1'b1, 32'd2, 16'd2, 32'd4);
        @(negedge clk);
        chk("b_granted_next", bus.ent_32, 32'd81);
        wait_ack(200, cyc, ok);
        chk("rr_b_before_a", 32'(ack_b), 32'd1);
        pop_check();
        drop(1'b1);
        wait_ack(200, cyc, ok);
        chk("rr_a_after_b", 32'(ack_a), 32'd1);
        pop_check();
        drop(1'b0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        int  cyc;
        bit  ok;
        vec_t v;

        vecs[0] = '{who: 1'b0, dm: 1'b1, e32: 32'h0000_0003, e16: 16'h0005, exp: 32'd15};
        vecs[1] = '{who: 1'b1, dm: 1'b0, e32: 32'd100,       e16: 16'd7,    exp: 32'd14};
        vecs[2] = '{who: 1'b0, dm: 1'b0, e32: 32'hFFFF_FFFF, e16: 16'h0001, exp: 32'hFFFF_FFFF};
        vecs[3] = '{who: 1'b1, dm: 1'b1, e32: 32'hABCD_FFFF, e16: 16'hFFFF, exp: 32'hFFFE_0001};
        vecs[4] = '{who: 1'b0, dm: 1'b1, e32: 32'h1234_0010, e16: 16'h0100, exp: 32'h0000_1000};
        vecs[5] = '{who: 1'b1, dm: 1'b0, e32: 32'd1000,      e16: 16'd1000, exp: 32'd1};

        rst_n = 1'b0;
        req_a = 1'b0; div_mult_a = 1'b0; ent_32_a = '0; ent_16_a = '0;
        req_b = 1'b0; div_mult_b = 1'b0; ent_32_b = '0; ent_16_b = '0;
        shadow_a = '0; shadow_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(bus.go), 32'd0);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_ack_b", 32'(ack_b), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sal_a", sal_32_a, 32'd0);
        chk("rst_sal_b", sal_32_b, 32'd0);
        chk("rst_ent_32", bus.ent_32, 32'd0);
        chk("rst_ent_16", 32'(bus.ent_16), 32'd0);
        chk("rst_div_mult", 32'(bus.div_mult), 32'd0);
        rst_n = 1'b1;

        tie_pair();

        for (int i = 0; i < 6; i++) do_vec(vecs[i], 1'b1);

        // done stuck high at grant: stay in ARM with go low
        hold = 1'b1;
        set_req(1'b0, 1'b1, 32'd9, 16'd9, 32'd81);
        repeat (10) @(negedge clk);
        chk("arm_go_low", 32'(bus.go), 32'd0);
        chk("arm_latched", bus.ent_32, 32'd9);
        hold = 1'b0;
        @(negedge clk);
        chk("arm_go_rise", 32'(bus.go), 32'd1);
        wait_ack(200, cyc, ok);
        pop_check();
        drop(1'b0);
        repeat (2) @(negedge clk);

        // Unit never completes: watchdog abort after 64 RUN cycles
        stall = 1'b1;
        set_req(1'b1, 1'b1, 32'd5, 16'd5, RESULT_ABORT);
        cyc = 0;
        while (cyc < 20 && !bus.go) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.go) fail_to("to_go");
        wait_ack(200, cyc, ok);
        chk("to_cycles", 32'(cyc), 32'd64);
        chk("to_err", 32'(err), 32'd1);
        chk("to_go_low", 32'(bus.go), 32'd0);
        pop_check();
        stall = 1'b0;
        drop(1'b1);
        repeat (2) @(negedge clk);
        v = '{who: 1'b1, dm: 1'b1, e32: 32'd12, e16: 16'd11, exp: 32'd132};
        do_vec(v, 1'b1);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of RUN
        set_req(1'b0, 1'b1, 32'd3, 16'd3, 32'd9);
        cyc = 0;
        while (cyc < 20 && !bus.go) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.go) fail_to("rr_go");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        req_a = 1'b0;
        @(negedge clk);
        chk("mid_rst_go", 32'(bus.go), 32'd0);
        chk("mid_rst_ack_a", 32'(ack_a), 32'd0);
        chk("mid_rst_ack_b", 32'(ack_b), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_sal_a", sal_32_a, 32'd0);
        chk("mid_rst_sal_b", sal_32_b, 32'd0);
        sb.delete();
        shadow_a = '0; shadow_b = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        tie_pair();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_arbiter.md
Name: mult_div_arbiter

Overview:
- Shares the single sequential multiplier/divider unit between two requesters, A and B.
- Arbitrates round-robin and latches the winner's operands onto the unit's ent_32/ent_16/div_mult inputs.
- Sequences the unit's go/done handshake: drop go, wait for done low, raise go, wait for done high. Then returns the result to the winner over a four-phase req/ack handshake.
- Sits between client logic and the mult/div core. A watchdog aborts a hung operation.

Parameters:
- TIMEOUT, 64, maximum cycles spent in RUN waiting for done=1 before abort (must be >= 2)
- CNT_W, 7, width of the watchdog counter; must hold TIMEOUT

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- req_a  input  1  requester A request; held high with stable operands until ack_a seen
- div_mult_a  input  1  A operation select: 1 = multiply, 0 = divide
- ent_32_a  input  32  A operand 1 (multiply uses [15:0])
- ent_16_a  input  16  A operand 2
- ack_a  output  1  A result valid; high until req_a drops
- sal_32_a  output  32  A result register (product or quotient)
- req_b, div_mult_b, ent_32_b, ent_16_b, ack_b, sal_32_b  same as A, for requester B
- ent_32  output  32  operand 1 to unit
- ent_16  output  16  operand 2 to unit
- div_mult  output  1  operation select to unit
- go  output  1  start to unit
- sal_32  input  32  unit result
- done  input  1  unit completion
- err  output  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; go, ack_a, ack_b, err = 0; ent_32, ent_16, div_mult, sal_32_a, sal_32_b = 0; last_grant=B (so A wins the first tie); counter=0. Reset mid-operation abandons the op immediately; go drops the following cycle.
- All outputs are registered.
- IDLE:
  - If req_a XOR req_b, grant the requester that is asserting.
  - If both are asserting, grant the one not equal to last_grant.
  - On grant: latch that requester's ent_32/ent_16/div_mult into the unit outputs, record owner, update last_grant, go to ARM.
  - Unit operand outputs hold their last values while idle.
- ARM: go=0. When done==0, go to RUN and set go=1 the next cycle. Stays in ARM indefinitely while done stays 1 (not watchdogged).
- RUN:
  - go=1; counter increments each cycle.
  - If done==1: capture sal_32 into the owner's sal_32_x, assert ack_x, go=0, go to ACK.
  - Else if counter reaches TIMEOUT-1: load 32'hFFFF_FFFF into sal_32_x, set err=1, assert ack_x, go=0, go to ACK.
  - Counter clears on entry to RUN.
- ACK: ack_x held high; the other ack stays 0. When the owner's req_x==0, drop ack_x and go to IDLE.
- Requester rules:
  - A requester that withdraws req while in ARM or RUN is still served; its ack stays until req is seen low.
  - Operand changes after grant are ignored (already latched).
- Minimum latency from req_x rising (idle arbiter, done low, unit done after k cycles of go):
  - cycle 0: req sampled
  - cycle 1: ARM
  - cycle 2: go=1
  - cycle 2+k: done sampled
  - cycle 3+k: ack_x=1 with sal_32_x valid
- The non-owner's sal_32 register is never modified.
- A request arriving while busy waits. Round-robin guarantees B is served next if A re-requests while B is pending.
- Only one operation is outstanding on the unit at any time; go is never high outside RUN.

Decomposition:
- Shared package mult_div_pkg:
  - state encoding constants IDLE=2'd0, ARM=2'd1, RUN=2'd2, ACK=2'd3
  - owner encoding OWN_A=1'b0, OWN_B=1'b1
  - TIMEOUT default
  - RESULT_ABORT=32'hFFFF_FFFF
- One sub-module is natural: rr_arb2 (combinational 2-way round-robin pick from req_a, req_b, last_grant). It is instantiated in the IDLE decision.
- The FSM, operand latches, result registers and watchdog stay in mult_div_arbiter.

Test Plan:
- Bench model of the unit: sets done=1 k=5 cycles after go rises; clears done 1 cycle after go falls.
- A alone, div_mult_a=1, ent_32_a=32'h0000_0003, ent_16_a=16'h0005 -> go=1 at cycle 2; ack_a=1 at cycle 8 with sal_32_a=32'd15. ack_b stays 0 and sal_32_b stays 0.
- B alone, divide, ent_32_b=32'd100, ent_16_b=16'd7 -> unit sees div_mult=0; sal_32_b=32'd14 with ack_b. ack_b drops the cycle after req_b falls.
- req_a and req_b rise together right after reset -> A granted first (ent_32=ent_32_a). After A's ack/release, B is granted with no idle gap beyond one IDLE cycle. A re-requesting while B is pending is served after B.
- done held high by the model when a grant occurs -> arbiter stays in ARM with go=0 until done falls; go rises exactly one cycle after done is seen low.
- Model never raises done -> after TIMEOUT=64 cycles in RUN: err=1, ack_x=1, sal_32_x=32'hFFFF_FFFF, go=0. A subsequent request completes normally with err still 1.
- rst_n pulsed low during RUN -> next cycle go=0, ack=0, err=0, all result regs 0. The first tie after reset again grants A.
